// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, transmitter start/data/done and grant status for uart_tx_arbiter.
// The master modport is the arbiter's view; the slave modport is the clients' and transmitter's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 grant_valid;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_start, tx_data, grant_valid, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter across NUM_REQ byte streams; a grant lasts up to BURST_MAX bytes or a last byte.
// Latency: valid->tx_start 2 cycles, tx_done->grant release 1 cycle; a requester waits until its byte pulses req_ready.
// UART_ARB_TIMEOUT_EN adds a tx_done watchdog that sets a sticky timeout_err and releases the grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BURST_MAX      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int         IW       = $clog2(NUM_REQ);
  localparam logic [3:0] NREQ4    = 4'(NUM_REQ);
  localparam logic [2:0] LAST_ID  = 3'(NUM_REQ - 1);
  localparam logic [7:0] LAST_CNT = 8'(BURST_MAX - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst
    $error("uart_tx_arbiter: BURST_MAX must be 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  typedef enum logic [1:0] {ARB, SEND, WAIT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic               last_flag_q, last_flag_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;

  logic [7:0]    req_byte [NUM_REQ];
  logic [IW-1:0] owner;
  logic [2:0]    next_ptr;
  logic [3:0]    scan;
  logic [2:0]    arb_pick;
  logic          arb_hit;
  logic          rel_grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
    assign req_byte[g] = bus.req_data[8*g +: 8];
  end

  assign owner    = grant_id_q[IW-1:0];
  assign next_ptr = (grant_id_q == LAST_ID) ? 3'd0 : grant_id_q + 3'd1;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = rr_ptr_q;
    scan     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + 4'(i);
      if (scan >= NREQ4) scan = scan - NREQ4;
      if (!arb_hit && bus.req_valid[scan[IW-1:0]]) begin
        arb_hit  = 1'b1;
        arb_pick = scan[2:0];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    byte_cnt_d    = byte_cnt_q;
    last_flag_d   = last_flag_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    req_ready_d   = '0;
    rel_grant     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ARB: begin
        if (arb_hit) begin
          grant_id_d    = arb_pick;
          grant_valid_d = 1'b1;
          byte_cnt_d    = 8'd0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (bus.req_valid[owner]) begin
          tx_start_d         = 1'b1;
          req_ready_d[owner] = 1'b1;
          tx_data_d          = req_byte[owner];
          last_flag_d        = bus.req_last[owner] || (byte_cnt_q == LAST_CNT);
          byte_cnt_d         = byte_cnt_q + 8'd1;
          state_d            = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wdog_d             = 16'd0;
`endif
        end else begin
          rel_grant = 1'b1;
        end
      end
      WAIT: begin
        // tx_done wins over a watchdog expiry in the same cycle.
        if (bus.tx_done) begin
          if (last_flag_q) rel_grant = 1'b1;
          else             state_d   = SEND;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wdog_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          rel_grant     = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      default: state_d = ARB;
    endcase
    if (rel_grant) begin
      grant_valid_d = 1'b0;
      rr_ptr_d      = next_ptr;
      state_d       = ARB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      rr_ptr_q      <= 3'd0;
      grant_id_q    <= 3'd0;
      grant_valid_q <= 1'b0;
      byte_cnt_q    <= 8'd0;
      last_flag_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'd0;
      req_ready_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      byte_cnt_q    <= byte_cnt_d;
      last_flag_q   <= last_flag_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      req_ready_q   <= req_ready_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q        <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q != ARB);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a transmitter model drive the DUT; a scoreboard checks each tx_start.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .BURST_MAX(3), .TIMEOUT_CYCLES(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  rq [4][$];   // {last, data} per requester
  logic [10:0] exp_q [$];   // {grant_id, data} in expected send order
  int cyc = 0, n_starts = 0, last_start_cyc = 0, last_done_cyc = 0, gv_fall_cyc = 0;
  int vld_rise_cyc [4];
  int tx_cnt = 0;
  int tx_lat = 10;
  bit tx_hold = 0, force_done = 0, gv_prev = 0;

  function automatic bit rq_empty();
    return rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
  endfunction

  // Requesters, transmitter and scoreboard monitor, acting just after each rising edge.
  initial begin
    logic [10:0] e;
    logic [8:0]  ent;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0 && !tx_hold) bus.tx_done = 1'b1;
      end
      if (force_done) begin
        bus.tx_done = 1'b1;
        force_done  = 0;
      end
      if (bus.tx_done) last_done_cyc = cyc;
      if (bus.tx_start) begin
        n_starts++;
        last_start_cyc = cyc;
        tx_cnt = tx_lat;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: tx_start id=%0d data=%h, no send expected", bus.grant_id, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.grant_id, bus.tx_data} !== e || bus.req_ready !== (4'b0001 << bus.grant_id)) begin
            n_fail++;
            $display("FAIL sb_send: got id=%0d data=%h ready=%b, want id=%0d data=%h ready=%b",
                     bus.grant_id, bus.tx_data, bus.req_ready, e[10:8], e[7:0], 4'b0001 << e[10:8]);
          end
        end
      end else if (bus.req_ready !== 4'b0000) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_without_start: req_ready=%b, want 0000", bus.req_ready);
      end
      for (int i = 0; i < 4; i++)
        if (bus.req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < 4; i++) begin
        if (rq[i].size() > 0) begin
          ent = rq[i][0];
          if (!bus.req_valid[i]) vld_rise_cyc[i] = cyc;
          bus.req_valid[i]       = 1'b1;
          bus.req_last[i]        = ent[8];
          bus.req_data[8*i +: 8] = ent[7:0];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
      if (gv_prev && !bus.grant_valid) gv_fall_cyc = cyc;
      gv_prev = bus.grant_valid;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && rq_empty() && !bus.busy && tx_cnt == 0) && n < 3000);
    n_tests++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s_idle: still busy after %0d cycles, %0d sends outstanding, want 0", name, n, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rst_grant_valid: got %b want 0", bus.grant_valid); end
    n_tests++; if (bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d want 0", bus.grant_id); end
    n_tests++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx: got start=%b data=%h want 0/00", bus.tx_start, bus.tx_data); end
    n_tests++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_ready_busy: got %b/%b want 0000/0", bus.req_ready, bus.busy); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b want 0", bus.timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    rq[0].push_back({1'b1, 8'h01}); rq[0].push_back({1'b1, 8'h02});
    rq[2].push_back({1'b1, 8'h21}); rq[2].push_back({1'b1, 8'h22});
    exp_q.push_back({3'd0, 8'h01}); exp_q.push_back({3'd2, 8'h21});
    exp_q.push_back({3'd0, 8'h02}); exp_q.push_back({3'd2, 8'h22});
    wait_idle("round_robin");
  endtask

  task automatic test_single();
    @(negedge clk);
    rq[1].push_back({1'b1, 8'h55});
    exp_q.push_back({3'd1, 8'h55});
    wait_idle("single");
    n_tests++; if (last_start_cyc - vld_rise_cyc[1] != 2) begin n_fail++; $display("FAIL single_start_latency: got %0d want 2", last_start_cyc - vld_rise_cyc[1]); end
    n_tests++; if (gv_fall_cyc - last_done_cyc != 1) begin n_fail++; $display("FAIL single_release_latency: got %0d want 1", gv_fall_cyc - last_done_cyc); end
    // rr_ptr is now 2, so requester 3 is chosen ahead of requester 1.
    rq[1].push_back({1'b1, 8'h61}); rq[3].push_back({1'b1, 8'h63});
    exp_q.push_back({3'd3, 8'h63}); exp_q.push_back({3'd1, 8'h61});
    wait_idle("rr_ptr");
  endtask

  task automatic test_burst_limit();
    for (int b = 0; b < 5; b++) rq[3].push_back({1'b0, 8'hA0 + 8'(b)});
    rq[0].push_back({1'b1, 8'h0F});
    for (int b = 0; b < 3; b++) exp_q.push_back({3'd3, 8'hA0 + 8'(b)});
    exp_q.push_back({3'd0, 8'h0F});
    exp_q.push_back({3'd3, 8'hA3}); exp_q.push_back({3'd3, 8'hA4});
    wait_idle("burst_limit");
  endtask

  task automatic test_drop();
    rq[1].push_back({1'b0, 8'h11});
    rq[2].push_back({1'b1, 8'h22});
    exp_q.push_back({3'd1, 8'h11}); exp_q.push_back({3'd2, 8'h22});
    wait_idle("drop");
  endtask

  task automatic test_reset_mid();
    int s0 = n_starts;
    int t = 0;
    rq[0].push_back({1'b0, 8'h31}); rq[0].push_back({1'b1, 8'h32});
    exp_q.push_back({3'd0, 8'h31});
    while (n_starts == s0 && t < 100) begin @(negedge clk); t++; end
    n_tests++; if (n_starts == s0) begin n_fail++; $display("FAIL rmid_first_send: no tx_start in %0d cycles, want 1", t); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rq[0].delete();
    @(negedge clk);
    n_tests++; if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_grant: got valid=%b busy=%b want 0/0", bus.grant_valid, bus.busy); end
    n_tests++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_outputs: got start=%b data=%h ready=%b want 0/00/0000", bus.tx_start, bus.tx_data, bus.req_ready); end
    n_tests++; if (bus.grant_id !== 3'd0) begin n_fail++; $display("FAIL rmid_grant_id: got %0d want 0", bus.grant_id); end
    rst = 1'b0;
    s0 = n_starts;
    repeat (20) @(negedge clk);
    n_tests++; if (n_starts != s0) begin n_fail++; $display("FAIL rmid_no_start: got %0d extra tx_start want 0", n_starts - s0); end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int s0 = n_starts;
    int t = 0;
    int s;
    tx_hold = 1;
    rq[2].push_back({1'b1, 8'h77}); rq[3].push_back({1'b1, 8'h78});
    exp_q.push_back({3'd2, 8'h77}); exp_q.push_back({3'd3, 8'h78});
    while (n_starts == s0 && t < 100) begin @(negedge clk); t++; end
    s = last_start_cyc;
    t = 0;
    while (cyc < s + 19 && t < 100) begin @(negedge clk); t++; end
    n_tests++; if (bus.timeout_err !== 1'b0 || bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL to_before: got err=%b grant=%b want 0/1", bus.timeout_err, bus.grant_valid); end
    @(negedge clk);
    n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", bus.timeout_err); end
    n_tests++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL to_release: got %b want 0", bus.grant_valid); end
    tx_hold = 0;
    wait_idle("timeout_next");
    n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", bus.timeout_err); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", bus.timeout_err); end
  endtask
`else
  task automatic test_no_timeout();
    tx_hold = 1;
    rq[2].push_back({1'b1, 8'h77});
    exp_q.push_back({3'd2, 8'h77});
    repeat (60) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1 || bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL nto_hold: got busy=%b grant=%b want 1/1", bus.busy, bus.grant_valid); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL nto_flag: got %b want 0", bus.timeout_err); end
    tx_hold = 0;
    force_done = 1;
    wait_idle("no_timeout");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_burst_limit();
    test_drop();
    test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
